// File: rtl/serial_sub4.sv
// serial_sub4: 4-bit bit-serial subtractor computing (a - b - bin) mod 16.
// One bit is processed per clock, LSB first. The result and the borrow-out
// are published together on the edge that enters DONE, and they hold until
// the next operation completes.
module serial_sub4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] d,
  output logic       bout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_acc;
  logic [3:0] r_d;
  logic [1:0] r_cnt;
  logic       r_brw;
  logic       r_busy;
  logic       r_done;
  logic       r_bout;

  logic       w_ai;
  logic       w_bi;
  logic       w_diff;
  logic       w_brwNext;
  logic [3:0] w_accNext;

  // Full-subtractor slice for the bit currently selected by the counter.
  // Each new difference bit enters the accumulator at the MSB, so after
  // four shifts the LSB-first bits sit in their natural positions.
  always_comb begin
    w_ai      = r_a[r_cnt];
    w_bi      = r_b[r_cnt];
    w_diff    = w_ai ^ w_bi ^ r_brw;
    w_brwNext = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_brw);
    w_accNext = {w_diff, r_acc[3:1]};
  end

  // Control FSM with the datapath registers. busy and done are registered
  // alongside the state so that each one is high exactly while in its state.
  // A start seen during SHIFT is simply not looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_acc   <= 4'd0;
      r_d     <= 4'd0;
      r_cnt   <= 2'd0;
      r_brw   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_brw   <= bin;
            r_acc   <= 4'd0;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_acc <= w_accNext;
          r_brw <= w_brwNext;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_d     <= w_accNext;
            r_bout  <= w_brwNext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign d    = r_d;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: directed, table-driven bench for serial_sub4, plus
// hand-written sequences for ignored start, back-to-back start and
// asynchronous reset.
module tb_serial_sub4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bout;

  int testCount = 0;
  int failCount = 0;
  logic [3:0] heldD;
  logic       heldBout;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] expD;
    logic       expBout;
  } vec_t;

  vec_t vecs [9];

  serial_sub4 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout)
  );

  // Free-running clock; rising edges at 5, 15, 25 ... and falling edges at
  // 10, 20, 30 ..., where outputs are sampled and inputs are driven.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Present an operation with start for one edge, then scramble the operand
  // inputs so that only the latched copies can produce the right answer.
  // Returns at the falling edge right after the accepting edge.
  task automatic applyStimulus(input logic [3:0] va, input logic [3:0] vb, input logic vbin);
    start = 1'b1;
    a     = va;
    b     = vb;
    bin   = vbin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    bin   = ~vbin;
  endtask

  // Full operation with cycle-exact checks of busy, done, held and new result.
  task automatic runOp(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                       input logic [3:0] expD, input logic expBout);
    applyStimulus(va, vb, vbin);
    for (int i = 0; i < 4; i++) begin
      checkOutput("busy_shift", {7'd0, busy}, 8'd1);
      checkOutput("done_shift", {7'd0, done}, 8'd0);
      checkOutput("d_held", {4'd0, d}, {4'd0, heldD});
      checkOutput("bout_held", {7'd0, bout}, {7'd0, heldBout});
      @(negedge clk);
    end
    checkOutput("busy_done", {7'd0, busy}, 8'd0);
    checkOutput("done_pulse", {7'd0, done}, 8'd1);
    checkOutput("d_result", {4'd0, d}, {4'd0, expD});
    checkOutput("bout_result", {7'd0, bout}, {7'd0, expBout});
    heldD    = expD;
    heldBout = expBout;
    @(negedge clk);
    checkOutput("done_single", {7'd0, done}, 8'd0);
    checkOutput("busy_idle", {7'd0, busy}, 8'd0);
    checkOutput("d_idle", {4'd0, d}, {4'd0, heldD});
  endtask

  initial begin
    // a, b, bin, expected d, expected bout (hand-computed)
    vecs[0] = '{4'd9,  4'd3,  1'b1, 4'd5,  1'b0};
    vecs[1] = '{4'd3,  4'd5,  1'b1, 4'd13, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
    vecs[4] = '{4'd7,  4'd2,  1'b0, 4'd5,  1'b0};
    vecs[5] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
    vecs[6] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
    vecs[7] = '{4'd8,  4'd8,  1'b1, 4'd15, 1'b1};
    vecs[8] = '{4'd5,  4'd4,  1'b1, 4'd0,  1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    bin      = 1'b0;
    heldD    = 4'd0;
    heldBout = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_done", {7'd0, done}, 8'd0);
    checkOutput("rst_d", {4'd0, d}, 8'd0);
    checkOutput("rst_bout", {7'd0, bout}, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven operations
    for (int v = 0; v < 9; v++) begin
      runOp(vecs[v].a, vecs[v].b, vecs[v].bin, vecs[v].expD, vecs[v].expBout);
    end

    // start while busy is ignored: 9 - 3 - 0 must still give 6
    applyStimulus(4'd9, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ign_busy", {7'd0, busy}, 8'd1);
      if (i == 1) begin
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
        bin   = 1'b0;
      end
      if (i == 3) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("ign_done", {7'd0, done}, 8'd1);
    checkOutput("ign_d", {4'd0, d}, 8'd6);
    checkOutput("ign_bout", {7'd0, bout}, 8'd0);
    @(negedge clk);
    checkOutput("ign_idle_busy", {7'd0, busy}, 8'd0);
    checkOutput("ign_idle_done", {7'd0, done}, 8'd0);

    // start held high: new operation on every DONE, done every 5 cycles
    start = 1'b1;
    a     = 4'd7;
    b     = 4'd2;
    bin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 15; n++) begin
      checkOutput("cont_busy", {7'd0, busy}, ((n % 5) < 4) ? 8'd1 : 8'd0);
      checkOutput("cont_done", {7'd0, done}, ((n % 5) == 4) ? 8'd1 : 8'd0);
      if (n >= 4) begin
        checkOutput("cont_d", {4'd0, d}, 8'd5);
        checkOutput("cont_bout", {7'd0, bout}, 8'd0);
      end
      if (n == 14) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("cont_end_busy", {7'd0, busy}, 8'd0);
    checkOutput("cont_end_done", {7'd0, done}, 8'd0);
    checkOutput("cont_end_d", {4'd0, d}, 8'd5);

    // Asynchronous reset in the cycle after the 2nd SHIFT edge
    applyStimulus(4'd3, 4'd5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", {7'd0, busy}, 8'd0);
    checkOutput("arst_done", {7'd0, done}, 8'd0);
    checkOutput("arst_d", {4'd0, d}, 8'd0);
    checkOutput("arst_bout", {7'd0, bout}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("arst_no_done", {7'd0, done}, 8'd0);
      checkOutput("arst_no_busy", {7'd0, busy}, 8'd0);
      checkOutput("arst_d_zero", {4'd0, d}, 8'd0);
    end
    heldD    = 4'd0;
    heldBout = 1'b0;

    // start accepted on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    runOp(4'd3, 4'd5, 1'b1, 4'd13, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/serial_sub4.md
SERIAL_SUB4 -- requirements
Module: serial_sub4

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to begin a subtraction; sampled on rising clk.
REQ-004 The block SHALL have the port a, input, 4 bits: minuend, unsigned; sampled only on an accepted start.
REQ-005 The block SHALL have the port b, input, 4 bits: subtrahend, unsigned; sampled only on an accepted start.
REQ-006 The block SHALL have the port bin, input, 1 bit: borrow-in; sampled only on an accepted start.
REQ-007 The block SHALL have the port busy, output, 1 bit: high while a subtraction is in progress.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking valid d/bout.
REQ-009 The block SHALL have the port d, output, 4 bits: difference (a - b - bin) mod 16.
REQ-010 The block SHALL have the port bout, output, 1 bit: borrow-out, high iff a < b + bin.

Function
REQ-011 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; an accepted start latches a, b and bin, clears the internal result register and bit counter, and enters SHIFT.
REQ-013 In SHIFT the block SHALL process one bit per clock, LSB first: diff_i = a_i ^ b_i ^ brw; brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw); brw is initialised from bin.
REQ-014 The bit counter SHALL run 0..3; on the edge that processes bit 3 the state SHALL become DONE.
REQ-015 Latency SHALL be fixed: start accepted at edge k, done high during the cycle after edge k+4, with d/bout valid in that same cycle.
REQ-016 busy SHALL be high exactly while in SHIFT, i.e. for 4 cycles per operation.
REQ-017 done SHALL be high for exactly one cycle, in DONE; DONE SHALL return to IDLE on the next edge unless start is high, in which case it enters SHIFT directly.
REQ-018 d and bout SHALL update only on the edge entering DONE and SHALL hold their value through IDLE and the whole of the following operation until the next DONE.
REQ-019 start asserted while in SHIFT SHALL be ignored, with no effect on latched operands, counter or outputs.
REQ-020 Changes on a, b or bin outside an accepted start SHALL NOT affect the result in progress.
REQ-021 All arithmetic SHALL be 4-bit modulo-16 plus borrow; the case 0 - 0 - 1 SHALL yield d = 15, bout = 1.

Reset
REQ-022 While rst is high, regardless of clk, the block SHALL force IDLE, busy = 0, done = 0, d = 0, bout = 0, and clear the counter, borrow and operand registers.
REQ-023 Reset asserted mid-SHIFT SHALL abort the operation, leaving no partial result on d.
REQ-024 On the first rising clk after rst deasserts, a high start SHALL be accepted normally.

Verification
REQ-025 a=9, b=3, bin=1, pulse start -> after 5 edges done=1, d=5, bout=0; busy high for 4 cycles.
REQ-026 a=3, b=5, bin=1 -> d=13 (4'b1101), bout=1.
REQ-027 a=0, b=0, bin=1 -> d=15, bout=1; then a=15, b=15, bin=0 -> d=0, bout=0.
REQ-028 start a=9, b=3, bin=0; 2 cycles later, while busy, drive start=1 with a=1, b=1 -> start is ignored and the result is d=6, bout=0.
REQ-029 Hold start high continuously with a=7, b=2, bin=0 -> a new operation begins on every DONE cycle: done pulses every 5 cycles, and d=5 is held between pulses.
REQ-030 Assert rst asynchronously during the cycle after the 2nd SHIFT edge -> busy, done, d and bout go to 0 immediately, without waiting for clk; no done pulse follows after rst is released.
